adder_issue_scheduler: RTL and testbench
========================================

ADDER_ISSUE_SCHEDULER -- requirements
Module: adder_issue_scheduler

Interface
REQ-001 Parameter: LATENCY, 2, adder pipeline depth in cycles from dispatch to result-buffer load (legal 1..4).
REQ-002 Parameter: DATA_W, 8, operand/result width.
REQ-003 Clock  input  1  single clock, all state on rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Ready  input  8  bit i=1: RS entry i busy with Qj=Qk=0; bit 0 unused, ignored.
REQ-006 RdTag  output  3  entry index being read this cycle; equals DispTag.
REQ-007 Vj, Vk  input  DATA_W each  operands of entry RdTag, combinational same-cycle read.
REQ-008 OpSub  input  1  operation of entry RdTag: 0=add, 1=subtract.
REQ-009 Dispatch  output  1  one-cycle pulse: entry DispTag issued to adder.
REQ-010 DispTag  output  3  entry issued; 0 when Dispatch=0.
REQ-011 CdbReq  output  1  result buffer holds a result awaiting the common data bus.
REQ-012 CdbGrant  input  1  CDB arbiter grant; valid only while CdbReq=1.
REQ-013 CdbTag, CdbValue  output  3, DATA_W  broadcast tag/value, valid while CdbReq=1.
REQ-014 Free  output  1  one-cycle pulse on the cycle CdbReq&CdbGrant; RS clears Busy[FreeTag].
REQ-015 FreeTag  output  3  equals CdbTag when Free=1, else 0.

Function
REQ-016 InFlight[7:1] register: set on dispatch of entry i, cleared on Free of entry i; candidates = Ready & ~InFlight, bit 0 forced 0.
REQ-017 Selection: round-robin over entries 1..7 starting at Ptr; Ptr reset to 1, after dispatch Ptr = DispTag+1, 7 wraps to 1.
REQ-018 Dispatch=1 iff candidates nonzero and pipeline stage 1 can accept this cycle (REQ-021).
REQ-019 Result = Vj+Vk (OpSub=0) or Vj-Vk (OpSub=1), modulo 2^DATA_W, no carry/overflow output; computed from Vj/Vk sampled at dispatch edge.
REQ-020 Pipeline: LATENCY stages of {valid, tag, value}; final stage loads result buffer.
REQ-021 Stall: buffer full and no grant this cycle freezes all stages holding valid data; a stage advances iff next stage empty or advancing; stage 1 accepts iff empty or advancing.
REQ-022 Result buffer FSM: EMPTY -> FULL on load; FULL -> EMPTY on grant with no load; FULL stays FULL when grant and load coincide (new result replaces old in same edge).
REQ-023 CdbReq = (state==FULL); CdbTag/CdbValue stable while FULL and not granted.
REQ-024 Back-to-back: with continuous grant and candidates, one dispatch and one Free per cycle in steady state.
REQ-025 Entry cannot be dispatched twice before its Free; Ready deasserting while in flight has no effect on the pipeline.
REQ-026 Free of entry i and a new Ready on entry i in same cycle: entry i not a candidate until the following cycle.
REQ-027 CdbGrant while CdbReq=0 is ignored.

Reset
REQ-028 Resetn=0 asynchronously clears: InFlight=0, Ptr=1, all stage valids=0, buffer EMPTY, Dispatch=0, DispTag=0, RdTag=0, CdbReq=0, CdbTag=0, CdbValue=0, Free=0, FreeTag=0.
REQ-029 Reset mid-operation discards in-flight results with no Free issued; first dispatch possible on first rising edge after release.

Structure
REQ-030 Shared package tomasulo_pkg holds TAG_W=3, NUM_RS=7, DATA_W default, OP_ADD/OP_SUB encoding, tag 0 = "no dependency".
REQ-031 One sub-module rr_picker: 7-bit request vector plus pointer in, one-hot grant and 3-bit tag out, combinational.

Verification
REQ-032 Ready=0b0000_0100, Vj=5, Vk=3, OpSub=0, grant held 1 -> Dispatch with DispTag=2, CdbReq after LATENCY cycles with CdbValue=8, Free pulse FreeTag=2.
REQ-033 Ready=0b1111_1110 static, grant held 1 -> DispTag order 1,2,...,7,(wait for Free)1; never same tag twice in flight.
REQ-034 Vj=3, Vk=5, OpSub=1 -> CdbValue=0xFE; Vj=0xFF, Vk=0x02, OpSub=0 -> 0x01.
REQ-035 Grant held 0 with Ready=0b0000_1110 -> buffer FULL, pipeline fills, Dispatch stops after 1+LATENCY issues; grant raised -> results emerge in dispatch order, one per cycle.
REQ-036 Resetn pulsed low while two entries in flight -> all outputs 0 immediately, no Free for those tags, Ptr=1 on release.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag width, station count, opcodes.
// Tag 0 is reserved to mean "no dependency / no entry".
package tomasulo_pkg;

    localparam int TAG_W      = 3;
    localparam int NUM_RS     = 7;
    localparam int DATA_W_DEF = 8;

    localparam logic [TAG_W-1:0] NO_TAG = '0;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/adder_issue_scheduler_if.sv
// Reservation-station / CDB side bundle of the adder issue scheduler.
// master = RS array plus CDB arbiter, slave = scheduler.
interface adder_issue_scheduler_if #(
    parameter int DATA_W = 8
);
    import tomasulo_pkg::*;

    logic [7:0]        Ready;
    logic [TAG_W-1:0]  RdTag;
    logic [DATA_W-1:0] Vj;
    logic [DATA_W-1:0] Vk;
    logic              OpSub;
    logic              Dispatch;
    logic [TAG_W-1:0]  DispTag;
    logic              CdbReq;
    logic              CdbGrant;
    logic [TAG_W-1:0]  CdbTag;
    logic [DATA_W-1:0] CdbValue;
    logic              Free;
    logic [TAG_W-1:0]  FreeTag;

    modport master (
        output Ready, Vj, Vk, OpSub, CdbGrant,
        input  RdTag, Dispatch, DispTag, CdbReq,
        input  CdbTag, CdbValue, Free, FreeTag
    );

    modport slave (
        input  Ready, Vj, Vk, OpSub, CdbGrant,
        output RdTag, Dispatch, DispTag, CdbReq,
        output CdbTag, CdbValue, Free, FreeTag
    );

endinterface

// File: rtl/adder_issue_scheduler_rr_picker.sv
// Round-robin picker over stations 1..NUM_RS; bit k of i_req is station k+1.
// Search starts at station i_ptr and wraps.
module rr_picker
    import tomasulo_pkg::*;
(
    input  logic [NUM_RS-1:0] i_req,
    input  logic [TAG_W-1:0]  i_ptr,
    output logic [NUM_RS-1:0] o_gnt,
    output logic [TAG_W-1:0]  o_tag
);

    always_comb begin
        logic       w_hit;
        logic [2:0] w_idx;
        o_gnt = '0;
        o_tag = NO_TAG;
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            w_idx = 3'((int'(i_ptr) + NUM_RS - 1 + k) % NUM_RS);
            if (!w_hit && i_req[w_idx]) begin
                w_hit        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_tag        = TAG_W'(w_idx) + TAG_W'(1);
            end
        end
    end

endmodule

// File: rtl/adder_issue_scheduler.sv
// Issue scheduler for a pipelined add/sub unit: picks ready stations,
// runs them through LATENCY stages and holds one result for the CDB.
module adder_issue_scheduler
    import tomasulo_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DATA_W  = DATA_W_DEF
)(
    input  logic                    Clock,
    input  logic                    Resetn,
    adder_issue_scheduler_if.slave  bus
);

    logic [NUM_RS-1:0] r_inflight;
    logic [TAG_W-1:0]  r_ptr;
    buf_state_e        r_state;
    logic [TAG_W-1:0]  r_btag;
    logic [DATA_W-1:0] r_bval;

    logic [NUM_RS-1:0] w_cand;
    logic [NUM_RS-1:0] w_gnt;
    logic [NUM_RS-1:0] w_disp_oh;
    logic [NUM_RS-1:0] w_free_oh;
    logic [TAG_W-1:0]  w_pick;
    logic [TAG_W-1:0]  w_disp_tag;
    logic              w_disp;
    logic              w_grant;
    logic [DATA_W-1:0] w_result;
    logic              w_ok [LATENCY+1];
    logic              w_last_vld;
    logic [TAG_W-1:0]  w_last_tag;
    logic [DATA_W-1:0] w_last_val;

    assign w_cand = bus.Ready[NUM_RS:1] & ~r_inflight;

    rr_picker u_pick (
        .i_req (w_cand),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_tag (w_pick)
    );

    assign w_grant     = (r_state == BUF_FULL) & bus.CdbGrant;
    assign w_ok[LATENCY] = (r_state == BUF_EMPTY) | w_grant;

    // Resetn gates the combinational outputs so they read 0 during reset
    assign w_disp     = Resetn & (|w_cand) & w_ok[0];
    assign w_disp_tag = w_disp ? w_pick : NO_TAG;
    assign w_disp_oh  = w_disp ? w_gnt : '0;
    assign w_free_oh  = w_grant ? (NUM_RS'(1) << 3'(r_btag - 3'd1)) : '0;

    assign w_result = (op_e'(bus.OpSub) == OP_SUB) ? bus.Vj - bus.Vk
                                                   : bus.Vj + bus.Vk;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
        logic              r_vld;
        logic [TAG_W-1:0]  r_tag;
        logic [DATA_W-1:0] r_val;
        logic              w_iv;
        logic [TAG_W-1:0]  w_it;
        logic [DATA_W-1:0] w_ival;

        if (k == 0) begin : g_head
            assign w_iv   = w_disp;
            assign w_it   = w_disp_tag;
            assign w_ival = w_result;
        end else begin : g_body
            assign w_iv   = g_stg[k-1].r_vld;
            assign w_it   = g_stg[k-1].r_tag;
            assign w_ival = g_stg[k-1].r_val;
        end

        // a stage may load when empty or when its content moves on
        assign w_ok[k] = !r_vld | w_ok[k+1];

        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                r_vld <= 1'b0;
                r_tag <= NO_TAG;
                r_val <= '0;
            end else if (w_ok[k]) begin
                r_vld <= w_iv;
                r_tag <= w_it;
                r_val <= w_ival;
            end
        end
    end

    assign w_last_vld = g_stg[LATENCY-1].r_vld;
    assign w_last_tag = g_stg[LATENCY-1].r_tag;
    assign w_last_val = g_stg[LATENCY-1].r_val;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_inflight <= '0;
            r_ptr      <= TAG_W'(1);
            r_state    <= BUF_EMPTY;
            r_btag     <= NO_TAG;
            r_bval     <= '0;
        end else begin
            r_inflight <= (r_inflight & ~w_free_oh) | w_disp_oh;
            if (w_disp)
                r_ptr <= (w_pick == TAG_W'(NUM_RS)) ? TAG_W'(1)
                                                    : w_pick + TAG_W'(1);
            unique case (r_state)
                BUF_EMPTY: begin
                    if (w_last_vld) begin
                        r_state <= BUF_FULL;
                        r_btag  <= w_last_tag;
                        r_bval  <= w_last_val;
                    end
                end
                BUF_FULL: begin
                    if (w_grant && w_last_vld) begin
                        r_btag <= w_last_tag;
                        r_bval <= w_last_val;
                    end else if (w_grant) begin
                        r_state <= BUF_EMPTY;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
        end
    end

    assign bus.Dispatch = w_disp;
    assign bus.DispTag  = w_disp_tag;
    assign bus.RdTag    = w_disp_tag;
    assign bus.CdbReq   = (r_state == BUF_FULL);
    assign bus.CdbTag   = r_btag;
    assign bus.CdbValue = r_bval;
    assign bus.Free     = w_grant;
    assign bus.FreeTag  = w_grant ? r_btag : NO_TAG;

endmodule

// File: tb/tb_adder_issue_scheduler.sv
// Directed bench for adder_issue_scheduler: vector table for single ops,
// hand sequences for round-robin, CDB stall and mid-flight reset.
module tb_adder_issue_scheduler;

    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n;

    adder_issue_scheduler_if #(.DATA_W(8)) ifc ();

    adder_issue_scheduler #(.LATENCY(LATENCY), .DATA_W(8)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] vj_tab [8];
    logic [7:0] vk_tab [8];
    logic       op_tab [8];

    assign ifc.Vj    = vj_tab[ifc.RdTag];
    assign ifc.Vk    = vk_tab[ifc.RdTag];
    assign ifc.OpSub = op_tab[ifc.RdTag];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         tag;
        logic [7:0] vj;
        logic [7:0] vk;
        logic       op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input int t);
        return op_tab[t] ? vj_tab[t] - vk_tab[t] : vj_tab[t] + vk_tab[t];
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, "_disp"}, ifc.Dispatch, 0);
        chk({nm, "_disptag"}, ifc.DispTag, 0);
        chk({nm, "_rdtag"}, ifc.RdTag, 0);
        chk({nm, "_cdbreq"}, ifc.CdbReq, 0);
        chk({nm, "_cdbtag"}, ifc.CdbTag, 0);
        chk({nm, "_cdbval"}, ifc.CdbValue, 0);
        chk({nm, "_free"}, ifc.Free, 0);
        chk({nm, "_freetag"}, ifc.FreeTag, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.Ready = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nd;
        int nf;
        int cnt;
        int q[$];
        logic [7:0] infl;

        vecs[0] = '{2, 8'd5,   8'd3,   1'b0, 8'd8};
        vecs[1] = '{1, 8'd3,   8'd5,   1'b1, 8'hFE};
        vecs[2] = '{7, 8'hFF,  8'h02,  1'b0, 8'h01};
        vecs[3] = '{4, 8'h80,  8'h80,  1'b0, 8'h00};
        vecs[4] = '{5, 8'h00,  8'h01,  1'b1, 8'hFF};
        vecs[5] = '{3, 8'h10,  8'h01,  1'b1, 8'h0F};

        for (int i = 0; i < 8; i++) begin
            vj_tab[i] = 8'(10 * i + 7);
            vk_tab[i] = 8'(3 * i + 1);
            op_tab[i] = i[0];
        end

        // reset holds every output low even with requests and grant up
        rst_n = 1'b0;
        ifc.Ready = 8'hFE;
        ifc.CdbGrant = 1'b1;
        #2 chk_idle("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        ifc.Ready = 8'h00;
        rst_n = 1'b1;

        // single-operation vectors
        for (int i = 0; i < 6; i++) begin
            vj_tab[vecs[i].tag] = vecs[i].vj;
            vk_tab[vecs[i].tag] = vecs[i].vk;
            op_tab[vecs[i].tag] = vecs[i].op;
            ifc.Ready = 8'(1 << vecs[i].tag);
            @(negedge clk);
            chk("vec_disp", ifc.Dispatch, 1);
            chk("vec_disptag", ifc.DispTag, vecs[i].tag);
            chk("vec_rdtag", ifc.RdTag, vecs[i].tag);
            @(posedge clk);
            #1 ifc.Ready = 8'h00;
            n = 1;
            @(negedge clk);
            while (!ifc.CdbReq && n < 20) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            chk("vec_latency", n, LATENCY + 1);
            chk("vec_cdbtag", ifc.CdbTag, vecs[i].tag);
            chk("vec_cdbval", ifc.CdbValue, vecs[i].exp);
            chk("vec_free", ifc.Free, 1);
            chk("vec_freetag", ifc.FreeTag, vecs[i].tag);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("grant_idle_req", ifc.CdbReq, 0);
        chk("grant_idle_free", ifc.Free, 0);

        // round-robin, back-to-back with grant held high
        for (int i = 1; i < 8; i++) begin
            vj_tab[i] = 8'(20 * i + 3);
            vk_tab[i] = 8'(7 * i);
            op_tab[i] = i[1];
        end
        @(posedge clk);
        #1;
        do_reset();
        ifc.Ready = 8'hFE;
        nd = 0;
        nf = 0;
        infl = 8'h00;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (ifc.Dispatch) begin
                chk("rr_no_double", infl[ifc.DispTag], 0);
                if (nd < 14)
                    chk("rr_order", ifc.DispTag, (nd % 7) + 1);
            end
            if (ifc.Free) begin
                if (q.size() == 0) begin
                    chk("rr_free_unexpected", ifc.FreeTag, 0);
                end else begin
                    n = q.pop_front();
                    chk("rr_free_tag", ifc.FreeTag, n);
                    chk("rr_free_val", ifc.CdbValue, model(n));
                end
                infl[ifc.FreeTag] = 1'b0;
                nf++;
            end
            if (ifc.Dispatch) begin
                infl[ifc.DispTag] = 1'b1;
                q.push_back(int'(ifc.DispTag));
                nd++;
            end
        end
        chk("rr_disp_count", nd, 24);
        chk("rr_free_count", nf, 24 - (LATENCY + 1));
        @(posedge clk);
        #1 ifc.Ready = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifc.Free && q.size() > 0) begin
                n = q.pop_front();
                chk("rr_drain_tag", ifc.FreeTag, n);
            end
        end
        chk("rr_drain_empty", q.size(), 0);

        // CDB stall: grant low fills buffer and pipeline
        @(posedge clk);
        #1;
        ifc.CdbGrant = 1'b0;
        do_reset();
        ifc.Ready = 8'h0E;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifc.Dispatch) cnt++;
        end
        chk("stall_disp_count", cnt, LATENCY + 1);
        chk("stall_cdbreq", ifc.CdbReq, 1);
        chk("stall_cdbtag", ifc.CdbTag, 1);
        chk("stall_cdbval", ifc.CdbValue, model(1));
        chk("stall_nofree", ifc.Free, 0);
        @(posedge clk);
        #1 ifc.CdbGrant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_free", ifc.Free, 1);
            chk("stall_freetag", ifc.FreeTag, i + 1);
            chk("stall_freeval", ifc.CdbValue, model(i + 1));
        end
        @(posedge clk);
        #1 ifc.Ready = 8'h00;
        repeat (10) @(negedge clk);
        chk("stall_drained", ifc.CdbReq, 0);

        // reset with two entries in flight
        @(posedge clk);
        #1;
        do_reset();
        ifc.Ready = 8'h06;
        @(negedge clk);
        chk("mid_disp1", ifc.DispTag, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_disp2", ifc.DispTag, 2);
        @(posedge clk);
        #1 ifc.Ready = 8'h00;
        #2 rst_n = 1'b0;
        #1 chk_idle("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifc.Free || ifc.CdbReq) cnt++;
        end
        chk("mid_no_free", cnt, 0);
        @(posedge clk);
        #1 ifc.Ready = 8'h84;
        @(negedge clk);
        chk("mid_ptr_disp", ifc.Dispatch, 1);
        chk("mid_ptr_tag", ifc.DispTag, 2);
        @(posedge clk);
        #1 ifc.Ready = 8'h00;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
